grid_env_step: RTL and testbench
================================

# grid_env_step

Environment-step initiator for the Q-learning grid world. It accepts a (row, col, action) step request from the agent and issues a single read to the registered reward-table ROM. It captures the returned reward, computes the next state, the wall-bump flag and the goal flag, and presents the result on a valid/ready response port. It sits between the agent/Q-update pipeline and the reward table, and drives that table's address/read side.

## Interface
Parameters:
- ROW_W, 3: row index width; the grid has 2^ROW_W rows.
- COL_W, 3: column index width; the grid has 2^COL_W columns.
- ACT_W, 2: action width. Encoding: 00 left, 01 up, 10 right, 11 down.
- DATA_WIDTH, 8: reward width.
- GOAL_ROW, 7: goal row index.
- GOAL_COL, 7: goal column index.
- CNT_W, 16: width of the per-episode step counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_req_valid  in  1  step request valid.
- o_req_ready  out  1  block can accept a request.
- i_row  in  ROW_W  current row.
- i_col  in  COL_W  current column.
- i_action  in  ACT_W  chosen action.
- o_rt_addr  out  ROW_W+COL_W+ACT_W  reward-table address, {row, col, action}.
- o_rt_read  out  1  reward-table read strobe.
- i_rt_data  in  DATA_WIDTH  reward-table data. Registered in the table, valid the cycle after the address is sampled.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  consumer accepts the response.
- o_reward  out  DATA_WIDTH  reward, i_rt_data passed through unmodified.
- o_next_row  out  ROW_W  next-state row.
- o_next_col  out  COL_W  next-state column.
- o_wall  out  1  the move would have left the grid; state unchanged.
- o_done  out  1  next state equals (GOAL_ROW, GOAL_COL).
- o_step_count  out  CNT_W  completed steps in the current episode.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. All outputs are registered.
- **IDLE:** o_req_ready=1. On the edge where i_req_valid && o_req_ready:
  - latch row, col and action;
  - set o_rt_addr <= {i_row, i_col, i_action} and o_rt_read <= 1;
  - set o_req_ready <= 0;
  - go to ISSUE.
- **ISSUE:** the table samples o_rt_addr at the closing edge. That edge sets o_rt_read <= 0 and moves to CAPTURE.
- **CAPTURE:** i_rt_data is valid. The closing edge:
  - loads o_reward, o_next_row, o_next_col, o_wall and o_done;
  - sets o_rsp_valid <= 1;
  - moves to RESP.
- **RESP:** all response outputs hold stable while i_rsp_ready=0. On the edge where o_rsp_valid && i_rsp_ready:
  - o_rsp_valid <= 0 and o_req_ready <= 1, return to IDLE;
  - o_step_count <= 0 if o_done=1; otherwise o_step_count <= o_step_count+1, saturating at all-ones.
- **Next-state rules:**
  - left: col-1, wall if col==0;
  - up: row-1, wall if row==0;
  - right: col+1, wall if col==max;
  - down: row+1, wall if row==max.
  - On a wall, next state = current state and o_wall=1.
- o_done is computed from the next state. A wall bump while standing on the goal therefore still reports done=1.
- o_wall and o_done are derived from the state only, never from the reward value.
- i_req_valid is ignored outside IDLE. i_rsp_ready is ignored outside RESP.
- o_rt_addr holds its last value after ISSUE.

## Timing
- Reset (asynchronous, any state, including mid-ISSUE or mid-CAPTURE):
  - FSM goes to IDLE;
  - o_req_ready, o_rt_read, o_rsp_valid, o_wall and o_done = 0;
  - o_rt_addr, o_reward, o_next_row, o_next_col and o_step_count = 0.
- o_req_ready rises at the first rising edge after i_rst_n deasserts.
- Latency: request accepted at edge E0. Then:
  - o_rt_read is high for exactly one cycle, E0 to E1;
  - o_rsp_valid rises at E2, 2 cycles after acceptance;
  - earliest response handshake is E3, and o_req_ready is high again after E3.
- Throughput: at most one step per 4 cycles with i_rsp_ready held high.
- The table's one-cycle registered read latency is fixed. The block never samples i_rt_data in any cycle other than CAPTURE.

## Test plan
- **Reset:**
  - Stimulus: bench ROM model (registered, 1-cycle read); assert i_rst_n=0 during CAPTURE.
  - Required: all outputs 0 immediately, with no o_rsp_valid afterwards.
  - Required: o_req_ready=1 at the first edge after release.
- **Interior move:**
  - Stimulus: (3,3) with action 10; model returns 0x00.
  - Required: o_rt_addr=0x6E with a one-cycle o_rt_read pulse.
  - Required: o_rsp_valid at E2 with next=(3,4), o_wall=0, o_done=0, o_reward=0x00, and o_step_count 0→1 after the handshake.
- **Wall:**
  - Stimulus: (0,5) with action 01; model returns 0x81.
  - Required: o_rt_addr=0x15; next=(0,5), o_wall=1, o_reward=0x81.
  - Same checks for (4,0) action 00 (0x80), (7,2) action 11 (0xEB) and (5,7) action 10 (0xBE).
- **Goal:**
  - Stimulus: (6,7) with action 11; model returns 0x7F.
  - Required: o_rt_addr=0xDF; next=(7,7), o_done=1, o_reward=0x7F.
  - Required: o_step_count=0 after the handshake.
  - Repeat with (7,6) action 10 (0xFA).
- **Backpressure:**
  - Stimulus: hold i_rsp_ready=0 for 5 cycles in RESP while toggling i_req_valid and the request inputs.
  - Required: response outputs stable, o_req_ready=0, and no new o_rt_read.
  - Required: after i_rsp_ready=1, exactly one handshake and a return to IDLE.
- **Counter saturation:**
  - Stimulus: CNT_W=4; run 20 non-goal steps.
  - Required: o_step_count reaches 15 and holds.
  - Then send one goal step; required: o_step_count=0.

Source files
------------

// File: rtl/grid_env_step.sv
// grid_env_step
//   Environment-step initiator for the Q-learning grid world. Accepts one
//   (row, col, action) step request and issues a single read to a registered
//   reward-table ROM. It captures the reward, computes the next state, the
//   wall-bump flag and the goal flag, and returns them on a valid/ready
//   response port.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready   step request handshake, with i_row/i_col/i_action
//   o_rt_addr/o_rt_read       reward-table address {row,col,action} and read strobe
//   i_rt_data                 reward-table data, valid one cycle after the address is sampled
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_reward, o_next_row/col  captured reward and next state
//   o_wall, o_done            wall bump, next state is the goal
//   o_step_count              completed steps in the current episode (saturating)
module grid_env_step #(
  parameter int ROW_W      = 3,
  parameter int COL_W      = 3,
  parameter int ACT_W      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int GOAL_ROW   = 7,
  parameter int GOAL_COL   = 7,
  parameter int CNT_W      = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ROW_W-1:0]             i_row,
  input  logic [COL_W-1:0]             i_col,
  input  logic [ACT_W-1:0]             i_action,
  output logic [ROW_W+COL_W+ACT_W-1:0] o_rt_addr,
  output logic                         o_rt_read,
  input  logic [DATA_WIDTH-1:0]        i_rt_data,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [DATA_WIDTH-1:0]        o_reward,
  output logic [ROW_W-1:0]             o_next_row,
  output logic [COL_W-1:0]             o_next_col,
  output logic                         o_wall,
  output logic                         o_done,
  output logic [CNT_W-1:0]             o_step_count
);

  localparam int ADDR_W = ROW_W + COL_W + ACT_W;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e                  state_q;
  logic [ROW_W-1:0]        row_q;
  logic [COL_W-1:0]        col_q;
  logic [ACT_W-1:0]        act_q;
  logic                    req_ready_q;
  logic [ADDR_W-1:0]       rt_addr_q;
  logic                    rt_read_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   reward_q;
  logic [ROW_W-1:0]        next_row_q;
  logic [COL_W-1:0]        next_col_q;
  logic                    wall_q;
  logic                    done_q;
  logic [CNT_W-1:0]        cnt_q;

  // Next-state of the latched request; a wall bump leaves the state as is.
  logic [ROW_W-1:0] next_row_d;
  logic [COL_W-1:0] next_col_d;
  logic             wall_d;
  logic             done_d;

  always_comb begin
    next_row_d = row_q;
    next_col_d = col_q;
    wall_d     = 1'b0;
    case (act_q[1:0])
      2'b00: if (col_q == '0) wall_d = 1'b1; else next_col_d = col_q - COL_W'(1);
      2'b01: if (row_q == '0) wall_d = 1'b1; else next_row_d = row_q - ROW_W'(1);
      2'b10: if (col_q == '1) wall_d = 1'b1; else next_col_d = col_q + COL_W'(1);
      default: if (row_q == '1) wall_d = 1'b1; else next_row_d = row_q + ROW_W'(1);
    endcase
    // Done looks at the next state, so bumping a wall while on the goal still reports done.
    done_d = (next_row_d == ROW_W'(GOAL_ROW)) && (next_col_d == COL_W'(GOAL_COL));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      act_q       <= '0;
      req_ready_q <= 1'b0;
      rt_addr_q   <= '0;
      rt_read_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      reward_q    <= '0;
      next_row_q  <= '0;
      next_col_q  <= '0;
      wall_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Ready comes out of reset low and rises on the first edge after release.
          if (req_ready_q && i_req_valid) begin
            row_q       <= i_row;
            col_q       <= i_col;
            act_q       <= i_action;
            rt_addr_q   <= {i_row, i_col, i_action};
            rt_read_q   <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          // Table samples the address on this edge; strobe is a single cycle.
          rt_read_q <= 1'b0;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          reward_q    <= i_rt_data;
          next_row_q  <= next_row_d;
          next_col_q  <= next_col_d;
          wall_q      <= wall_d;
          done_q      <= done_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_valid_q && i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
            if (done_q)          cnt_q <= '0;
            else if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_rt_addr    = rt_addr_q;
  assign o_rt_read    = rt_read_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_reward     = reward_q;
  assign o_next_row   = next_row_q;
  assign o_next_col   = next_col_q;
  assign o_wall       = wall_q;
  assign o_done       = done_q;
  assign o_step_count = cnt_q;

endmodule

// File: tb/tb_grid_env_step.sv
// Directed bench for grid_env_step with a registered 1-cycle reward ROM model.
module tb_grid_env_step;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req_valid, o_req_ready;
  logic [2:0] i_row, i_col;
  logic [1:0] i_action;
  logic [7:0] o_rt_addr;
  logic       o_rt_read;
  logic [7:0] i_rt_data;
  logic       o_rsp_valid, i_rsp_ready;
  logic [7:0] o_reward;
  logic [2:0] o_next_row, o_next_col;
  logic       o_wall, o_done;
  logic [3:0] o_step_count;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  logic [7:0] mem [256];

  always #5 i_clk = ~i_clk;

  grid_env_step #(.CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_row(i_row), .i_col(i_col), .i_action(i_action),
    .o_rt_addr(o_rt_addr), .o_rt_read(o_rt_read), .i_rt_data(i_rt_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_reward(o_reward), .o_next_row(o_next_row), .o_next_col(o_next_col),
    .o_wall(o_wall), .o_done(o_done), .o_step_count(o_step_count)
  );

  // Registered ROM; outside a read it returns the inverted word so a
  // capture in the wrong cycle shows up as a wrong reward.
  always @(posedge i_clk) i_rt_data <= o_rt_read ? mem[o_rt_addr] : ~mem[o_rt_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] c, input logic [1:0] a,
                      input logic [7:0] eaddr, input logic [7:0] erew,
                      input logic [2:0] er, input logic [2:0] ec,
                      input logic ew, input logic ed, input int hold);
    chk("ready_pre", o_req_ready, 1);
    i_req_valid = 1'b1; i_row = r; i_col = c; i_action = a;
    @(posedge i_clk); #1;                      // E0
    i_req_valid = 1'b0;
    chk("rt_addr", o_rt_addr, eaddr);
    chk("rt_read_e0", o_rt_read, 1);
    chk("ready_e0", o_req_ready, 0);
    @(posedge i_clk); #1;                      // E1
    chk("rt_read_e1", o_rt_read, 0);
    chk("rsp_valid_e1", o_rsp_valid, 0);
    @(posedge i_clk); #1;                      // E2
    chk("rsp_valid_e2", o_rsp_valid, 1);
    chk("reward", o_reward, erew);
    chk("next_row", o_next_row, er);
    chk("next_col", o_next_col, ec);
    chk("wall", o_wall, ew);
    chk("done", o_done, ed);
    chk("cnt_pre", o_step_count, exp_cnt);
    for (int k = 0; k < hold; k++) begin
      i_req_valid = ~i_req_valid;
      i_row = 3'($urandom); i_col = 3'($urandom); i_action = 2'($urandom);
      @(posedge i_clk); #1;
      chk("bp_valid", o_rsp_valid, 1);
      chk("bp_reward", o_reward, erew);
      chk("bp_next", {o_next_row, o_next_col}, {er, ec});
      chk("bp_flags", {o_wall, o_done}, {ew, ed});
      chk("bp_ready", o_req_ready, 0);
      chk("bp_rt_read", o_rt_read, 0);
      chk("bp_rt_addr", o_rt_addr, eaddr);
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;                      // E3
    i_rsp_ready = 1'b0;
    if (ed) exp_cnt = 0;
    else if (exp_cnt != 15) exp_cnt++;
    chk("rsp_valid_e3", o_rsp_valid, 0);
    chk("ready_e3", o_req_ready, 1);
    chk("step_count", o_step_count, exp_cnt);
    if (hold > 0) begin
      @(posedge i_clk); #1;
      chk("idle_valid", o_rsp_valid, 0);
      chk("idle_read", o_rt_read, 0);
      chk("idle_ready", o_req_ready, 1);
      chk("idle_count", o_step_count, exp_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] tr [4];
    logic [2:0] tc [4];
    logic [7:0] ad;
    tr[0] = 3'd2; tc[0] = 3'd1;   // left
    tr[1] = 3'd1; tc[1] = 3'd2;   // up
    tr[2] = 3'd2; tc[2] = 3'd3;   // right
    tr[3] = 3'd3; tc[3] = 3'd2;   // down
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h6E] = 8'h00;
    mem[8'h15] = 8'h81;
    mem[8'hDF] = 8'h7F;

    i_rst_n = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
    i_row = '0; i_col = '0; i_action = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_outs", {o_rt_read, o_rsp_valid, o_wall, o_done}, 0);
    chk("rst_data", {o_rt_addr, o_reward, o_next_row, o_next_col, o_step_count}, 0);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("ready_after_rst", o_req_ready, 1);

    // Reset asserted mid-CAPTURE.
    i_req_valid = 1'b1; i_row = 3'd3; i_col = 3'd3; i_action = 2'b10;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    chk("mid_rt_read", o_rt_read, 1);
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {o_req_ready, o_rt_read, o_rsp_valid, o_wall, o_done}, 0);
    chk("mid_rst_data", {o_rt_addr, o_reward, o_next_row, o_next_col, o_step_count}, 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("mid_rst_hold", o_rsp_valid, 0);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("mid_ready_after", o_req_ready, 1);
    chk("mid_no_rsp", o_rsp_valid, 0);

    // Interior, walls, goals.
    step(3'd3, 3'd3, 2'b10, 8'h6E, 8'h00, 3'd3, 3'd4, 1'b0, 1'b0, 0);
    step(3'd0, 3'd5, 2'b01, 8'h15, 8'h81, 3'd0, 3'd5, 1'b1, 1'b0, 0);
    step(3'd4, 3'd0, 2'b00, 8'h80, 8'hDA, 3'd4, 3'd0, 1'b1, 1'b0, 0);
    step(3'd7, 3'd2, 2'b11, 8'hEB, 8'hB1, 3'd7, 3'd2, 1'b1, 1'b0, 0);
    step(3'd5, 3'd7, 2'b10, 8'hBE, 8'hE4, 3'd5, 3'd7, 1'b1, 1'b0, 0);
    step(3'd6, 3'd7, 2'b11, 8'hDF, 8'h7F, 3'd7, 3'd7, 1'b0, 1'b1, 0);
    step(3'd7, 3'd6, 2'b10, 8'hFA, 8'hA0, 3'd7, 3'd7, 1'b0, 1'b1, 0);
    // Bumping a wall while on the goal still reports done.
    step(3'd7, 3'd7, 2'b10, 8'hFE, 8'hA4, 3'd7, 3'd7, 1'b1, 1'b1, 0);

    // Backpressure: 5 cycles of i_rsp_ready=0 with toggling request inputs.
    step(3'd2, 3'd1, 2'b01, 8'h45, 8'h1F, 3'd1, 3'd1, 1'b0, 1'b0, 5);

    // Counter saturation at 15, then cleared by a goal step.
    for (int i = 0; i < 20; i++) begin
      ad = 8'h48 + 8'(i % 4);
      step(3'd2, 3'd2, 2'(i % 4), ad, mem[ad], tr[i % 4], tc[i % 4], 1'b0, 1'b0, 0);
    end
    chk("cnt_saturated", o_step_count, 15);
    step(3'd6, 3'd7, 2'b11, 8'hDF, 8'h7F, 3'd7, 3'd7, 1'b0, 1'b1, 0);
    chk("cnt_cleared", o_step_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
